fetch_window: RTL and testbench

Parameterised fetch stage between the prefetch FIFO and the instruction decoder. It pops variable-length byte lines from the show-ahead prefetch FIFO into an internal byte buffer, and presents decode with a contiguous window of bytes that can span FIFO entries. Decode consumes any number of bytes per cycle. Prefetch GP and PF fault markers are held and reported only once every byte ahead of them has been consumed.

---
 rtl/fetch_window.sv | 116 +++++++++++
 tb/tb_fetch_window.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fetch_window.sv
// Fetch window: drains variable-length lines from the show-ahead prefetch FIFO into a byte
// buffer and presents decode with a contiguous window; fault markers surface once drained.
module fetch_window #(
  parameter int LINE_BYTES = 8,
  parameter int WIN_BYTES  = 16,
  parameter int BUF_BYTES  = 24,
  localparam int CW = $clog2(BUF_BYTES + 1),
  localparam int VW = $clog2(WIN_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pr_reset,
  input  logic [31:0]             wr_eip,
  output logic [31:0]             prefetch_eip,
  output logic                    prefetchfifo_accept_do,
  input  logic [LINE_BYTES*8+3:0] prefetchfifo_accept_data,
  input  logic                    prefetchfifo_accept_empty,
  output logic [WIN_BYTES*8-1:0]  fetch,
  output logic [VW-1:0]           fetch_valid,
  output logic                    fetch_limit,
  output logic                    fetch_page_fault,
  input  logic [VW-1:0]           dec_consume,
  output logic [CW-1:0]           fetch_level
);

  logic [3:0]              code;
  logic [LINE_BYTES*8-1:0] line;
  logic                    is_fault;
  logic                    illegal;
  logic [CW-1:0]           len;
  logic [CW-1:0]           eff_consume;
  logic [CW-1:0]           base;

  logic [CW-1:0]           level_q, level_d;
  logic                    fault_pend_q, fault_pend_d;
  logic                    fault_pf_q, fault_pf_d;
  logic [BUF_BYTES*8-1:0]  buf_q, buf_d;

  always_comb begin
    code     = prefetchfifo_accept_data[LINE_BYTES*8 +: 4];
    line     = prefetchfifo_accept_data[LINE_BYTES*8-1:0];
    is_fault = (code >= 4'd13);
    illegal  = !is_fault && (int'(code) > LINE_BYTES);
    len      = '0;
    if (!is_fault) len = illegal ? CW'(LINE_BYTES) : CW'(code);
  end

  always_comb begin
    fetch_valid = (int'(level_q) > WIN_BYTES) ? VW'(WIN_BYTES) : VW'(level_q);
    eff_consume = (int'(dec_consume) > int'(fetch_valid)) ? CW'(fetch_valid) : CW'(dec_consume);
    // Room is judged on the registered level only; same-cycle consumption earns no credit.
    prefetchfifo_accept_do = rst_n && !pr_reset && !fault_pend_q && !prefetchfifo_accept_empty &&
                             (is_fault || (int'(level_q) + int'(len) <= BUF_BYTES));
  end

  always_comb begin
    buf_d        = buf_q >> (8 * int'(eff_consume));
    base         = level_q - eff_consume;
    level_d      = base;
    fault_pend_d = fault_pend_q;
    fault_pf_d   = fault_pf_q;
    if (prefetchfifo_accept_do) begin
      if (is_fault) begin
        fault_pend_d = 1'b1;
        fault_pf_d   = (code == 4'd14);
      end else begin
        level_d = base + len;
        for (int i = 0; i < BUF_BYTES; i++) begin
          if (i >= int'(base) && i < int'(base) + int'(len))
            buf_d[i*8 +: 8] = line[(i - int'(base))*8 +: 8];
        end
      end
    end
    if (pr_reset) begin
      level_d      = '0;
      fault_pend_d = 1'b0;
      fault_pf_d   = 1'b0;
    end
  end

  always_comb begin
    fetch = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      if (i < int'(fetch_valid)) fetch[i*8 +: 8] = buf_q[i*8 +: 8];
    end
    fetch_limit      = fault_pend_q && !fault_pf_q && (level_q == '0);
    fetch_page_fault = fault_pend_q && fault_pf_q && (level_q == '0);
    fetch_level      = level_q;
    prefetch_eip     = wr_eip;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q      <= '0;
      fault_pend_q <= 1'b0;
      fault_pf_q   <= 1'b0;
    end else begin
      level_q      <= level_d;
      fault_pend_q <= fault_pend_d;
      fault_pf_q   <= fault_pf_d;
    end
  end

  // Buffer contents beyond the valid level are never observable, so no reset is needed.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n && !pr_reset) begin
      assert (!(prefetchfifo_accept_do && illegal));
      assert (int'(dec_consume) <= int'(fetch_valid));
    end
  end

endmodule

// File: tb/tb_fetch_window.sv
// Randomised bench for fetch_window: a queue-based byte model and FIFO model predict
// every output each cycle under phased stimulus (fill, faults, flushes, mid-run reset).
module tb_fetch_window;

  localparam int LB = 8;
  localparam int WB = 16;
  localparam int BB = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pr_reset;
  logic [31:0]       wr_eip;
  logic [31:0]       prefetch_eip;
  logic              accept_do;
  logic [LB*8+3:0]   accept_data;
  logic              accept_empty;
  logic [WB*8-1:0]   fetch;
  logic [4:0]        fetch_valid;
  logic              fetch_limit;
  logic              fetch_page_fault;
  logic [4:0]        dec_consume;
  logic [4:0]        fetch_level;

  logic [LB*8+3:0]   fifo_q[$];
  logic [7:0]        bq[$];
  bit                m_fault;
  bit                m_pf;
  int                n_checks = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  fetch_window #(.LINE_BYTES(LB), .WIN_BYTES(WB), .BUF_BYTES(BB)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .pr_reset                  (pr_reset),
    .wr_eip                    (wr_eip),
    .prefetch_eip              (prefetch_eip),
    .prefetchfifo_accept_do    (accept_do),
    .prefetchfifo_accept_data  (accept_data),
    .prefetchfifo_accept_empty (accept_empty),
    .fetch                     (fetch),
    .fetch_valid               (fetch_valid),
    .fetch_limit               (fetch_limit),
    .fetch_page_fault          (fetch_page_fault),
    .dec_consume               (dec_consume),
    .fetch_level               (fetch_level)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [LB*8+3:0] newEntry(input int fault_pct);
    logic [3:0]    c;
    logic [63:0]   d;
    if (int'($urandom_range(99)) < fault_pct) c = 4'(13 + $urandom_range(2));
    else                                      c = 4'($urandom_range(LB));
    d = {$urandom, $urandom};
    return {c, d};
  endfunction

  // One clock cycle: drive at the falling edge, check settled outputs, then advance the model.
  task automatic applyStimulus(input bit rst_v, input int consume_mode, input int flush_pct,
                               input int gap_pct, input int fault_pct, input bit check_window);
    bit              gap;
    int              exp_valid;
    int              consume;
    int              flush_p;
    logic [LB*8+3:0] head;
    int              hcode;
    bit              exp_acc;
    logic [127:0]    exp_fetch;

    @(negedge clk);
    while (fifo_q.size() < 4) fifo_q.push_back(newEntry(fault_pct));
    gap       = (int'($urandom_range(99)) < gap_pct);
    exp_valid = (bq.size() > WB) ? WB : bq.size();
    flush_p   = (m_fault && bq.size() == 0) ? 30 : flush_pct;
    case (consume_mode)
      0:       consume = 0;
      1:       consume = int'($urandom_range(exp_valid));
      default: consume = exp_valid;
    endcase
    rst_n        = rst_v;
    pr_reset     = (int'($urandom_range(99)) < flush_p);
    dec_consume  = 5'(consume);
    accept_empty = gap;
    accept_data  = gap ? {$urandom, $urandom, $urandom} : fifo_q[0];
    wr_eip       = $urandom;
    #1;

    head    = fifo_q[0];
    hcode   = int'(head[LB*8 +: 4]);
    exp_acc = rst_v && !pr_reset && !m_fault && !gap && (hcode >= 13 || bq.size() + hcode <= BB);
    exp_fetch = '0;
    for (int i = 0; i < exp_valid; i++) exp_fetch[i*8 +: 8] = bq[i];

    checkOutput("accept_do", 128'(accept_do), 128'(exp_acc));
    checkOutput("prefetch_eip", 128'(prefetch_eip), 128'(wr_eip));
    if (check_window) begin
      checkOutput("fetch_valid", 128'(fetch_valid), 128'(exp_valid));
      checkOutput("fetch", fetch, exp_fetch);
      checkOutput("fetch_level", 128'(fetch_level), 128'(bq.size()));
      checkOutput("fetch_limit", 128'(fetch_limit), 128'(m_fault && !m_pf && bq.size() == 0));
      checkOutput("fetch_page_fault", 128'(fetch_page_fault), 128'(m_fault && m_pf && bq.size() == 0));
    end

    if (!rst_v || pr_reset) begin
      bq.delete();
      m_fault = 1'b0;
      m_pf    = 1'b0;
    end else begin
      repeat (consume) void'(bq.pop_front());
      if (exp_acc) begin
        if (hcode >= 13) begin
          m_fault = 1'b1;
          m_pf    = (hcode == 14);
        end else begin
          for (int i = 0; i < hcode; i++) bq.push_back(head[i*8 +: 8]);
        end
      end
    end
    if (accept_do === 1'b1) void'(fifo_q.pop_front());
  endtask

  initial begin
    rst_n        = 1'b0;
    pr_reset     = 1'b0;
    wr_eip       = '0;
    dec_consume  = '0;
    accept_empty = 1'b1;
    accept_data  = '0;
    m_fault      = 1'b0;
    m_pf         = 1'b0;

    applyStimulus(1'b0, 0, 0, 0, 0, 1'b0);
    repeat (3)   applyStimulus(1'b0, 1, 0, 0, 0, 1'b1);
    repeat (12)  applyStimulus(1'b1, 0, 0, 0, 0, 1'b1);
    repeat (300) applyStimulus(1'b1, 1, 2, 10, 0, 1'b1);
    repeat (600) applyStimulus(1'b1, 1, 2, 15, 15, 1'b1);
    repeat (300) applyStimulus(1'b1, 2, 3, 10, 25, 1'b1);
    repeat (200) applyStimulus(1'b1, 0, 4, 5, 10, 1'b1);
    repeat (3)   applyStimulus(1'b0, 1, 0, 0, 0, 1'b1);
    repeat (600) applyStimulus(1'b1, 1, 3, 20, 10, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
